// File: rtl/hbm_mvm_trp_cmd_seq.sv
// hbm_mvm_trp_cmd_seq: ordered HBM weight/feature/output command stream for the post-transpose MVM
// ports: clk/rst (sync, active-high); start/abort control; cfg_* head/token/length/layout config,
// latched on an accepted start; cmd_valid/cmd_ready handshake carrying cmd_type (0 wt rd,
// 1 feat rd, 2 out wr), cmd_addr, cmd_len, cmd_head; busy level, done and err one-cycle pulses.
module hbm_mvm_trp_cmd_seq #(
    parameter int ADDR_W = 32,
    parameter int TOK_W  = 12,
    parameter int HEAD_W = 6,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [HEAD_W-1:0] cfg_feat_heads,
    input  logic [HEAD_W-1:0] cfg_wt_heads,
    input  logic [TOK_W-1:0]  cfg_tokens,
    input  logic [LEN_W-1:0]  cfg_in_len,
    input  logic [LEN_W-1:0]  cfg_out_len,
    input  logic              cfg_kv_mode,
    input  logic [ADDR_W-1:0] cfg_dat_base,
    input  logic [ADDR_W-1:0] cfg_dat_head_stride,
    input  logic [ADDR_W-1:0] cfg_dat_line_stride,
    input  logic [ADDR_W-1:0] cfg_wt_base,
    input  logic [ADDR_W-1:0] cfg_wt_head_stride,
    input  logic [ADDR_W-1:0] cfg_out_base,
    input  logic [ADDR_W-1:0] cfg_out_head_stride,
    input  logic [ADDR_W-1:0] cfg_out_line_stride,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    output logic [HEAD_W-1:0] cmd_head,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, CHECK, WT, FEAT, OUT, DONE, ERR} state_t;
    state_t state, state_nx;
    logic [HEAD_W-1:0] f_r, w_r, rem, grp, h, gi;
    logic [TOK_W-1:0]  t_r, t;
    logic [LEN_W-1:0]  in_len_r, out_len_r;
    logic [ADDR_W-1:0] dhs, dls, whs, ohs, ols;
    logic [ADDR_W-1:0] wt_addr, fh_addr, f_addr, oh_addr, o_addr;
    logic fire, go, bad, last_t, last_h, last_g;
    assign fire   = cmd_valid && cmd_ready;
    assign go     = start && !busy;
    assign bad    = f_r == '0 || w_r == '0 || t_r == '0 || in_len_r == '0 || out_len_r == '0 || w_r > f_r;
    assign last_t = t == t_r - TOK_W'(1);
    assign last_h = h == f_r - HEAD_W'(1);
    assign last_g = gi == grp - HEAD_W'(1);
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    // CHECK divides F by W through repeated subtraction: grp ends as F/W, rem as F mod W
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: state_nx = go ? CHECK : IDLE;
            CHECK:           state_nx = bad ? ERR : rem >= w_r ? CHECK : rem != '0 ? ERR : WT;
            WT:              state_nx = fire ? FEAT : WT;
            FEAT:            state_nx = fire ? OUT : FEAT;
            OUT:             state_nx = !fire ? OUT : !last_t ? FEAT : last_h ? DONE : last_g ? WT : FEAT;
            default:         state_nx = IDLE;
        endcase
        if (abort)
            state_nx = IDLE;
    end
    // address accumulators: *h_addr track the head start, f_addr/o_addr the current token line
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            {f_r, w_r, rem, grp, h, gi} <= '0;
            {t_r, t, in_len_r, out_len_r} <= '0;
            {dhs, dls, whs, ohs, ols} <= '0;
            {wt_addr, fh_addr, f_addr, oh_addr, o_addr} <= '0;
        end else if (go) begin
            f_r       <= cfg_feat_heads;
            w_r       <= cfg_wt_heads;
            t_r       <= cfg_tokens;
            in_len_r  <= cfg_in_len;
            out_len_r <= cfg_out_len;
            dhs       <= cfg_dat_head_stride;
            dls       <= cfg_dat_line_stride;
            whs       <= cfg_wt_head_stride;
            ohs       <= cfg_out_head_stride;
            ols       <= cfg_out_line_stride;
            rem       <= cfg_feat_heads;
            {grp, h, gi, t} <= '0;
            wt_addr   <= cfg_wt_base;
            fh_addr   <= cfg_dat_base;
            f_addr    <= cfg_dat_base;
            oh_addr   <= cfg_kv_mode ? cfg_dat_base : cfg_out_base;
            o_addr    <= cfg_kv_mode ? cfg_dat_base : cfg_out_base;
        end else if (state == CHECK && !bad && rem >= w_r) begin
            rem <= rem - w_r;
            grp <= grp + HEAD_W'(1);
        end else if (fire && state == OUT) begin
            if (!last_t) begin
                t      <= t + TOK_W'(1);
                f_addr <= f_addr + dls;
                o_addr <= o_addr + ols;
            end else if (!last_h) begin
                h       <= h + HEAD_W'(1);
                t       <= '0;
                fh_addr <= fh_addr + dhs;
                f_addr  <= fh_addr + dhs;
                oh_addr <= oh_addr + ohs;
                o_addr  <= oh_addr + ohs;
                gi      <= last_g ? '0 : gi + HEAD_W'(1);
                wt_addr <= last_g ? wt_addr + whs : wt_addr;
            end
        end
    end
    always_comb begin
        cmd_valid = state == WT || state == FEAT || state == OUT;
        busy      = cmd_valid || state == CHECK;
        done      = state == DONE;
        err       = state == ERR;
        cmd_type  = state == FEAT ? 2'd1 : state == OUT ? 2'd2 : 2'd0;
        cmd_addr  = state == WT ? wt_addr : state == FEAT ? f_addr : state == OUT ? o_addr : '0;
        cmd_len   = state == OUT ? out_len_r : cmd_valid ? in_len_r : '0;
        cmd_head  = cmd_valid ? h : '0;
    end
endmodule

// File: tb/tb_hbm_mvm_trp_cmd_seq.sv
// tb_hbm_mvm_trp_cmd_seq: table-driven scoreboard bench for the MVM command sequencer
module tb_hbm_mvm_trp_cmd_seq;
    localparam int ADDR_W = 32, TOK_W = 12, HEAD_W = 6, LEN_W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, abort = 1'b0, cmd_ready = 1'b0, cfg_kv_mode = 1'b0;
    logic [HEAD_W-1:0] cfg_feat_heads = '0, cfg_wt_heads = '0, cmd_head;
    logic [TOK_W-1:0]  cfg_tokens = '0;
    logic [LEN_W-1:0]  cfg_in_len = '0, cfg_out_len = '0, cmd_len;
    logic [ADDR_W-1:0] cfg_dat_base = '0, cfg_dat_head_stride = '0, cfg_dat_line_stride = '0;
    logic [ADDR_W-1:0] cfg_wt_base = '0, cfg_wt_head_stride = '0;
    logic [ADDR_W-1:0] cfg_out_base = '0, cfg_out_head_stride = '0, cfg_out_line_stride = '0;
    logic [ADDR_W-1:0] cmd_addr;
    logic [1:0] cmd_type;
    logic cmd_valid, busy, done, err;

    hbm_mvm_trp_cmd_seq #(.ADDR_W(ADDR_W), .TOK_W(TOK_W), .HEAD_W(HEAD_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_feat_heads(cfg_feat_heads), .cfg_wt_heads(cfg_wt_heads), .cfg_tokens(cfg_tokens),
        .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len), .cfg_kv_mode(cfg_kv_mode),
        .cfg_dat_base(cfg_dat_base), .cfg_dat_head_stride(cfg_dat_head_stride),
        .cfg_dat_line_stride(cfg_dat_line_stride), .cfg_wt_base(cfg_wt_base),
        .cfg_wt_head_stride(cfg_wt_head_stride), .cfg_out_base(cfg_out_base),
        .cfg_out_head_stride(cfg_out_head_stride), .cfg_out_line_stride(cfg_out_line_stride),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_head(cmd_head), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int f, w, t, in_len, out_len;
        bit kv;
        logic [31:0] dat_base, dhs, dls, wt_base, whs, out_base, ohs, ols;
        int duty;
        bit exp_err;
        int exp_cmds;
    } vec_t;
    typedef struct {
        logic [1:0] ty;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0] len;
        logic [HEAD_W-1:0] head;
    } cmd_t;

    vec_t vecs[9];
    cmd_t exp_q[$];
    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] pack(input cmd_t c);
        return {16'h0, c.ty, c.addr, c.len, c.head};
    endfunction

    function automatic logic [63:0] dut_cmd();
        return {16'h0, cmd_type, cmd_addr, cmd_len, cmd_head};
    endfunction

    // reference model: direct multiply-based address formulas
    task automatic build(input vec_t v);
        int g;
        cmd_t c;
        logic [31:0] ob;
        exp_q.delete();
        if (v.exp_err) return;
        g = v.f / v.w;
        ob = v.kv ? v.dat_base : v.out_base;
        for (int h = 0; h < v.f; h++) begin
            if (h % g == 0) begin
                c.ty = 2'd0; c.addr = v.wt_base + 32'(h / g) * v.whs;
                c.len = LEN_W'(v.in_len); c.head = HEAD_W'(h);
                exp_q.push_back(c);
            end
            for (int k = 0; k < v.t; k++) begin
                c.ty = 2'd1; c.addr = v.dat_base + 32'(h) * v.dhs + 32'(k) * v.dls;
                c.len = LEN_W'(v.in_len); c.head = HEAD_W'(h);
                exp_q.push_back(c);
                c.ty = 2'd2; c.addr = ob + 32'(h) * v.ohs + 32'(k) * v.ols;
                c.len = LEN_W'(v.out_len);
                exp_q.push_back(c);
            end
        end
    endtask

    task automatic run(input vec_t v, input int abort_at);
        cmd_t e;
        logic [63:0] held;
        bit stalled, fin, exp_done, quiet;
        int n, nwt;
        stalled = 0; fin = 0; exp_done = 0; n = 0; nwt = 0; held = '0;
        build(v);
        @(negedge clk);
        cfg_feat_heads = HEAD_W'(v.f); cfg_wt_heads = HEAD_W'(v.w); cfg_tokens = TOK_W'(v.t);
        cfg_in_len = LEN_W'(v.in_len); cfg_out_len = LEN_W'(v.out_len); cfg_kv_mode = v.kv;
        cfg_dat_base = v.dat_base; cfg_dat_head_stride = v.dhs; cfg_dat_line_stride = v.dls;
        cfg_wt_base = v.wt_base; cfg_wt_head_stride = v.whs;
        cfg_out_base = v.out_base; cfg_out_head_stride = v.ohs; cfg_out_line_stride = v.ols;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_feat_heads = HEAD_W'($urandom); cfg_wt_heads = HEAD_W'($urandom);
        cfg_tokens = TOK_W'($urandom); cfg_kv_mode = ~v.kv;
        cfg_dat_base = $urandom; cfg_out_base = $urandom; cfg_wt_base = $urandom;
        cfg_dat_line_stride = $urandom; cfg_out_line_stride = $urandom;
        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            if (exp_done) begin
                check("done_pulse", {61'h0, done, busy, cmd_valid}, 64'b100);
                fin = 1;
            end else if (err || done) begin
                if (v.exp_err) begin
                    check("err_busy", {61'h0, err, busy, cmd_valid}, 64'b100);
                    check("err_cmds", 64'(n), 64'd0);
                end else
                    check("early_end", {62'h0, err, done}, 64'd0);
                fin = 1;
            end else if (cmd_valid) begin
                if (stalled)
                    check("stable", dut_cmd(), held);
                if (n == abort_at && stalled) begin
                    cmd_ready = 1'b0;
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    check("abort_idle", {61'h0, cmd_valid, busy, done}, 64'd0);
                    quiet = 1;
                    repeat (4) begin
                        @(negedge clk);
                        if (done || cmd_valid || busy) quiet = 0;
                    end
                    check("abort_quiet", 64'(quiet), 64'd1);
                    fin = 1;
                end else begin
                    cmd_ready = n == abort_at ? 1'b0 : ($urandom_range(99) < v.duty);
                    if (cmd_ready) begin
                        if (exp_q.size() == 0) begin
                            check("extra_cmd", dut_cmd(), 64'd0);
                            fin = 1;
                        end else begin
                            e = exp_q.pop_front();
                            check("cmd", dut_cmd(), pack(e));
                            if (cmd_type == 2'd0) nwt++;
                            n++;
                            stalled = 0;
                            if (exp_q.size() == 0) exp_done = 1;
                        end
                    end else begin
                        stalled = 1;
                        held = dut_cmd();
                    end
                end
            end else
                cmd_ready = 1'($urandom_range(1));
            if (!fin) @(negedge clk);
        end
        if (!fin) check("timeout", 64'd0, 64'd1);
        if (!v.exp_err && abort_at < 0) begin
            check("cmd_count", 64'(n), 64'(v.exp_cmds));
            check("wt_count", 64'(nwt), 64'(v.w));
        end
        cmd_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32, 2, 19, 4, 1, 1'b0, 32'h0000_0000, 32'h1000, 32'h40, 32'h0200_0000, 32'h800,
                    32'h0400_0000, 32'h1000, 32'h40, 100, 1'b0, 1218};
        vecs[1] = '{32, 2, 19, 4, 1, 1'b1, 32'h0000_0000, 32'h1000, 32'h40, 32'h0200_0000, 32'h800,
                    32'h0800_0000, 32'h1000, 32'h40, 100, 1'b0, 1218};
        vecs[2] = vecs[0];
        vecs[2].duty = 30;
        vecs[3] = '{6, 4, 1, 4, 1, 1'b0, 32'h0, 32'h1000, 32'h40, 32'h0, 32'h800,
                    32'h0, 32'h1000, 32'h40, 100, 1'b1, 0};
        vecs[4] = '{0, 1, 1, 4, 1, 1'b0, 32'h0, 32'h1000, 32'h40, 32'h0, 32'h800,
                    32'h0, 32'h1000, 32'h40, 100, 1'b1, 0};
        vecs[5] = '{4, 4, 1, 2, 3, 1'b0, 32'h1000_0000, 32'h100, 32'h20, 32'h2000_0000, 32'h80,
                    32'h3000_0000, 32'h200, 32'h10, 100, 1'b0, 12};
        vecs[6] = '{1, 1, 2, 4, 1, 1'b0, 32'hFFFF_FFC0, 32'h1000, 32'h40, 32'h0, 32'h800,
                    32'h0, 32'h1000, 32'h40, 100, 1'b0, 5};
        vecs[7] = '{6, 3, 3, 2, 3, 1'b0, 32'h0001_0000, 32'h300, 32'h30, 32'h0005_0000, 32'h400,
                    32'h0009_0000, 32'h500, 32'h50, 50, 1'b0, 39};
        vecs[8] = '{4, 2, 0, 4, 1, 1'b0, 32'h0, 32'h1000, 32'h40, 32'h0, 32'h800,
                    32'h0, 32'h1000, 32'h40, 100, 1'b1, 0};
        repeat (2) @(negedge clk);
        check("reset_state", {54'h0, cmd_valid, busy, done, err, cmd_type, cmd_addr[3:0]}, 64'd0);
        check("reset_fields", {16'h0, cmd_addr, cmd_len, cmd_head}, 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 9; k++)
            run(vecs[k], -1);
        run(vecs[0], 99);
        run(vecs[0], -1);
        @(negedge clk);
        cfg_feat_heads = 6'd4; cfg_wt_heads = 6'd4; cfg_tokens = 12'd1;
        cfg_in_len = 8'd2; cfg_out_len = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", {63'h0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset", {16'h0, cmd_valid, busy, done, err, cmd_type, cmd_addr, cmd_len[3:0], cmd_head}, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
